// File: rtl/cmd_seq_pkg.sv
// Shared types and constants for the Knight command sequencer.
package cmd_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LOAD      = 3'd1,
        ST_SEND      = 3'd2,
        ST_WAIT_SENT = 3'd3,
        ST_WAIT_ACK  = 3'd4,
        ST_DONE      = 3'd5,
        ST_ERR       = 3'd6
    } seq_state_t;

    localparam logic [1:0] ERR_NONE = 2'b00;
    localparam logic [1:0] ERR_NAK  = 2'b01;
    localparam logic [1:0] ERR_TMO  = 2'b10;
    localparam logic [1:0] ERR_OVF  = 2'b11;

    localparam logic [7:0] POS_ACK_DEF = 8'hA5;

    // Knight command set: calibrate gyro, and move = {opcode, heading, squares}
    localparam logic [15:0] CAL_GYRO = 16'h2000;
    localparam logic [3:0]  MOVE_OP  = 4'h4;

    function automatic logic [15:0] knight_move(input logic [7:0] heading,
                                                input logic [3:0] squares);
        return {MOVE_OP, heading, squares};
    endfunction

endpackage

// File: rtl/cmd_fifo.sv
// Circular command queue; head is visible without popping. A push while full
// is accepted only when a pop happens on the same clock.
module cmd_fifo #(
    parameter int DEPTH = 8,
    parameter int CMD_W = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push_i,
    input  logic [CMD_W-1:0]           data_i,
    input  logic                       pop_i,
    input  logic                       flush_i,
    output logic [CMD_W-1:0]           head_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH+1);

    logic [CMD_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_push, do_pop;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    // Pointer and count bookkeeping; flush discards everything.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            if (do_push && !do_pop)      count_q <= count_q + 1'b1;
            else if (do_pop && !do_push) count_q <= count_q - 1'b1;
        end
    end

    // Storage array; contents are only meaningful below count.
    always_ff @(posedge clk) begin
        if (do_push && !flush_i) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/cmd_sequencer.sv
// Issues queued Knight commands one at a time, waits for the acknowledge
// with timeout and bounded retries, and reports completion or error.
//
// Handshake: send_cmd is a one-clock strobe with cmd stable from LOAD until
// the ack; cmd_sent completes transmission; resp is valid only while
// resp_rdy is high and only sampled in WAIT_ACK.
module cmd_sequencer
    import cmd_seq_pkg::*;
#(
    parameter int         DEPTH        = 8,
    parameter int         CMD_W        = 16,
    parameter int         TIMEOUT_CLKS = 1000000,
    parameter int         MAX_RETRY    = 2,
    parameter logic [7:0] POS_ACK      = POS_ACK_DEF
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       wr_en,
    input  logic [CMD_W-1:0]           wr_cmd,
    output logic                       full,
    input  logic                       start,
    input  logic                       abort,
    output logic [CMD_W-1:0]           cmd,
    output logic                       send_cmd,
    input  logic                       cmd_sent,
    input  logic                       resp_rdy,
    input  logic [7:0]                 resp,
    output logic                       busy,
    output logic                       done,
    output logic                       err,
    output logic [1:0]                 err_code,
    output logic [$clog2(DEPTH+1)-1:0] cmd_cnt,
    output seq_state_t                 dbg_state_o
);
    localparam int CNT_W = $clog2(DEPTH+1);
    localparam int TMR_W = (TIMEOUT_CLKS > 1) ? $clog2(TIMEOUT_CLKS) : 1;
    localparam int RTY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY+1) : 1;
    localparam logic [TMR_W-1:0] TMO_LAST = TMR_W'(TIMEOUT_CLKS-1);

    seq_state_t       state_q, state_d;
    logic [CMD_W-1:0] cmd_q, cmd_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic [RTY_W-1:0] retry_q, retry_d;
    logic             done_q, done_d, err_q, err_d;
    logic [1:0]       err_code_q, err_code_d;
    logic [CNT_W-1:0] cmd_cnt_q, cmd_cnt_d;
    logic             q_pop, q_flush, q_full, q_empty, send;
    logic [CMD_W-1:0] q_head;
    logic [CNT_W-1:0] q_count;

    cmd_fifo #(.DEPTH(DEPTH), .CMD_W(CMD_W)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (wr_en),
        .data_i  (wr_cmd),
        .pop_i   (q_pop),
        .flush_i (q_flush),
        .head_o  (q_head),
        .full_o  (q_full),
        .empty_o (q_empty),
        .count_o (q_count)
    );

    assign full        = q_full;
    assign cmd         = cmd_q;
    assign send_cmd    = send;
    assign done        = done_q;
    assign err         = err_q;
    assign err_code    = err_code_q;
    assign cmd_cnt     = cmd_cnt_q;
    assign dbg_state_o = state_q;
    assign busy        = (state_q == ST_LOAD) || (state_q == ST_SEND) ||
                         (state_q == ST_WAIT_SENT) || (state_q == ST_WAIT_ACK);

    // State and status registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            cmd_q      <= '0;
            timer_q    <= '0;
            retry_q    <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            err_code_q <= ERR_NONE;
            cmd_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            cmd_q      <= cmd_d;
            timer_q    <= timer_d;
            retry_q    <= retry_d;
            done_q     <= done_d;
            err_q      <= err_d;
            err_code_q <= err_code_d;
            cmd_cnt_q  <= cmd_cnt_d;
        end
    end

    // Next-state logic: normal flow, then queue overflow, then abort on top.
    always_comb begin
        state_d    = state_q;
        cmd_d      = cmd_q;
        timer_d    = timer_q;
        retry_d    = retry_q;
        done_d     = done_q;
        err_d      = err_q;
        err_code_d = err_code_q;
        cmd_cnt_d  = cmd_cnt_q;
        q_pop      = 1'b0;
        q_flush    = 1'b0;
        send       = 1'b0;

        case (state_q)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (start) begin
                    err_d      = 1'b0;
                    err_code_d = ERR_NONE;
                    cmd_cnt_d  = '0;
                    done_d     = q_empty;
                    state_d    = q_empty ? ST_DONE : ST_LOAD;
                end
            end
            ST_LOAD: begin
                cmd_d   = q_head;
                retry_d = '0;
                state_d = ST_SEND;
            end
            ST_SEND: begin
                send    = 1'b1;
                state_d = ST_WAIT_SENT;
            end
            ST_WAIT_SENT: begin
                if (cmd_sent) begin
                    timer_d = '0;
                    state_d = ST_WAIT_ACK;
                end
            end
            ST_WAIT_ACK: begin
                timer_d = (timer_q == TMO_LAST) ? timer_q : timer_q + 1'b1;
                if (resp_rdy) begin
                    if (resp == POS_ACK) begin
                        q_pop     = 1'b1;
                        cmd_cnt_d = cmd_cnt_q + 1'b1;
                        // A concurrent push keeps the queue non-empty.
                        if ((q_count == CNT_W'(1)) && !wr_en) begin
                            done_d  = 1'b1;
                            state_d = ST_DONE;
                        end else begin
                            state_d = ST_LOAD;
                        end
                    end else begin
                        err_d      = 1'b1;
                        err_code_d = ERR_NAK;
                        state_d    = ST_ERR;
                    end
                end else if (timer_q == TMO_LAST) begin
                    if (retry_q < RTY_W'(MAX_RETRY)) begin
                        retry_d = retry_q + 1'b1;
                        state_d = ST_SEND;
                    end else begin
                        err_d      = 1'b1;
                        err_code_d = ERR_TMO;
                        state_d    = ST_ERR;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (wr_en && q_full && !q_pop) begin
            err_d      = 1'b1;
            err_code_d = ERR_OVF;
            if (busy) state_d = ST_ERR;
        end

        if (abort) begin
            q_flush = 1'b1;
            q_pop   = 1'b0;
            send    = 1'b0;
            done_d  = 1'b0;
            state_d = ST_IDLE;
        end
    end

endmodule
